// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I data-memory path: funct3 codes and responder FSM states.
package rv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

endpackage

// File: rtl/rv_dmem_sram.sv
// Single-port 32-bit word array with per-byte write enables and synchronous read.
module rv_dmem_sram #(
    parameter int unsigned AW    = 10,
    parameter int unsigned DEPTH = 2 ** AW
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem [DEPTH];

    // A cycle with no byte enables is a read; the read register holds until the next read.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (be_i == '0) begin
                rdata_o <= mem[addr_i];
            end
            for (int unsigned b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/rv_dmem_responder.sv
// RV32I data-memory responder: valid/ready request, programmable wait states, lane steering and extension.
// Optional RV_DMEM_ERR_EN reports misaligned/invalid accesses on rsp_err_o instead of aligning them down.
module rv_dmem_responder
    import rv_pkg::*;
#(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o
);

    localparam int unsigned WA = ADDR_W - 2;

    dmem_state_t       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;

    logic              accept, access, do_write;
    logic              f3_ok, sz_b, sz_h, err_c;
    logic [1:0]        off;
    logic [3:0]        be;
    logic [31:0]       wlane, shifted, ext;

    logic [WA-1:0]     mem_addr;
    logic              mem_en;
    logic [3:0]        mem_be;
    logic [31:0]       mem_rdata;

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign rsp_rdata_o = rdata_q;
    assign accept      = req_valid_i & req_ready_o;
    assign access      = (state_q == WAIT) && (cnt_q == '0);
    assign do_write    = access & we_q & ~err_c;

    always_comb begin
        f3_ok = we_q ? (f3_q == F3_B || f3_q == F3_H || f3_q == F3_W)
                     : (f3_q == F3_B || f3_q == F3_H || f3_q == F3_W ||
                        f3_q == F3_BU || f3_q == F3_HU);
        sz_b  = f3_ok && (f3_q[1:0] == 2'b00);
        sz_h  = f3_ok && (f3_q[1:0] == 2'b01);
`ifdef RV_DMEM_ERR_EN
        err_c = !f3_ok || (sz_h && addr_q[0]) || (!sz_b && !sz_h && addr_q[1:0] != 2'b00);
        off   = addr_q[1:0];
`else
        err_c = 1'b0;
        off   = sz_b ? addr_q[1:0] : (sz_h ? {addr_q[1], 1'b0} : 2'b00);
`endif
        be      = sz_b ? (4'b0001 << off) : (sz_h ? (4'b0011 << off) : 4'b1111);
        wlane   = sz_b ? {4{wdata_q[7:0]}} : (sz_h ? {2{wdata_q[15:0]}} : wdata_q);
        shifted = mem_rdata >> {off, 3'b000};
        ext     = sz_b ? {{24{shifted[7] & ~f3_q[2]}}, shifted[7:0]}
                : sz_h ? {{16{shifted[15] & ~f3_q[2]}}, shifted[15:0]}
                : shifted;
    end

    // Loads read the array on the accept edge so the word is ready when the access edge registers it.
    assign mem_addr = req_ready_o ? req_addr_i[ADDR_W-1:2] : addr_q[ADDR_W-1:2];
    assign mem_en   = (accept & ~req_we_i) | do_write;
    assign mem_be   = do_write ? be : '0;

    rv_dmem_sram #(
        .AW (WA)
    ) u_sram (
        .clk_i   (clk_i),
        .en_i    (mem_en),
        .be_i    (mem_be),
        .addr_i  (mem_addr),
        .wdata_i (wlane),
        .rdata_o (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = WAIT;
                    cnt_d   = 4'(WAIT_CYCLES);
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we_i;
                f3_q    <= req_funct3_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
            end
            if (access) begin
                rdata_q <= (we_q || err_c) ? '0 : ext;
            end
        end
    end

`ifdef RV_DMEM_ERR_EN
    logic err_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (access) begin
            err_q <= err_c;
        end
    end
    assign rsp_err_o = err_q;
`else
    assign rsp_err_o = 1'b0;
`endif

endmodule
